// File: rtl/comm_pkg.sv
// Shared opcodes, acknowledge value and FSM state encoding for the command link.
package comm_pkg;
  localparam logic [7:0] REQ_BATT  = 8'h01;
  localparam logic [7:0] SET_PTCH  = 8'h02;
  localparam logic [7:0] SET_ROLL  = 8'h03;
  localparam logic [7:0] SET_YAW   = 8'h04;
  localparam logic [7:0] SET_THRST = 8'h05;
  localparam logic [7:0] CALIBRATE = 8'h06;
  localparam logic [7:0] EMER_LAND = 8'h07;
  localparam logic [7:0] MTRS_OFF  = 8'h08;
  localparam logic [7:0] POS_ACK   = 8'hA5;

  typedef enum logic [1:0] {IDLE, SEND, WAIT_TX, WAIT_RESP} state_t;
endpackage

// File: rtl/cmd_fifo.sv
// Command FIFO; a write is still accepted when full if a pop happens in the same cycle.
module cmd_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       full_o,
  output logic [$clog2(DEPTH+1)-1:0] cnt_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    cnt_q;
  logic             do_wr, do_pop;

  assign full_o = (cnt_q == CW'(DEPTH));
  assign do_pop = pop_i && (cnt_q != '0);
  assign do_wr  = wr_i && (!full_o || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_wr)  wptr_q <= wptr_q + AW'(1);
      if (do_pop) rptr_q <= rptr_q + AW'(1);
      cnt_q <= cnt_q + CW'(do_wr) - CW'(do_pop);
    end
  end

  // Storage carries no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rptr_q];
  assign cnt_o   = cnt_q;
endmodule

// File: rtl/comm_master_q.sv
// Queued command master: frames opcode + payload bytes MSB first onto a byte UART,
// waits for a one-byte reply and resends the frame on timeout.
module comm_master_q
  import comm_pkg::*;
#(
  parameter int DATA_BYTES  = 2,
  parameter int QDEPTH      = 4,
  parameter int TIMEOUT_CYC = 1_000_000,
  parameter int MAX_RETRY   = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [7:0]                  cmd,
  input  logic [8*DATA_BYTES-1:0]     data,
  input  logic                        snd_cmd,
  output logic                        q_full,
  output logic [$clog2(QDEPTH+1)-1:0] q_cnt,
  output logic                        ovfl,
  output logic [7:0]                  tx_data,
  output logic                        trmt,
  input  logic                        tx_done,
  input  logic [7:0]                  rx_data,
  input  logic                        rx_rdy,
  output logic                        clr_rx_rdy,
  output logic [7:0]                  resp,
  output logic                        resp_rdy,
  input  logic                        clr_resp_rdy,
  output logic                        frm_snt,
  output logic                        err,
  input  logic                        clr_err,
  output logic                        busy
);
  localparam int FW = 8 + 8*DATA_BYTES;
  localparam int BW = $clog2(DATA_BYTES+1);
  localparam int RW = $clog2(MAX_RETRY+2);
  localparam int TW = $clog2(TIMEOUT_CYC+1);

  state_t        state_q, state_d;
  logic [FW-1:0] shift_q, shift_d, head;
  logic [BW-1:0] byte_idx_q, byte_idx_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0]    tx_data_q, tx_data_d, resp_q, resp_d;
  logic          trmt_q, trmt_d, frm_q, frm_d, clr_rx_q, clr_rx_d;
  logic          resp_rdy_q, resp_rdy_d, err_q, err_d, ovfl_q, ovfl_d;
  logic          pop, err_new, rx_new, timeout;

  cmd_fifo #(.WIDTH(FW), .DEPTH(QDEPTH)) u_fifo (
    .clk(clk), .rst_n(rst_n), .wr_i(snd_cmd), .wdata_i({cmd, data}),
    .pop_i(pop), .rdata_o(head), .full_o(q_full), .cnt_o(q_cnt)
  );

  // rx_rdy is a level that stays high during the acknowledge cycle; don't count it twice.
  assign rx_new  = rx_rdy && !clr_rx_q;
  assign timeout = (timer_q == TW'(TIMEOUT_CYC-1));

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    byte_idx_d = byte_idx_q;
    retry_d    = retry_q;
    timer_d    = timer_q;
    tx_data_d  = tx_data_q;
    resp_d     = resp_q;
    trmt_d     = 1'b0;
    frm_d      = 1'b0;
    clr_rx_d   = rx_new;
    resp_rdy_d = resp_rdy_q && !clr_resp_rdy;
    pop        = 1'b0;
    err_new    = 1'b0;
    case (state_q)
      IDLE: if (q_cnt != '0) begin
        shift_d    = head;
        byte_idx_d = '0;
        retry_d    = '0;
        state_d    = SEND;
      end
      SEND: begin
        trmt_d    = 1'b1;
        tx_data_d = shift_q[FW-1 -: 8];
        state_d   = WAIT_TX;
      end
      WAIT_TX: if (tx_done) begin
        if (byte_idx_q < BW'(DATA_BYTES)) begin
          byte_idx_d = byte_idx_q + BW'(1);
          shift_d    = shift_q << 8;
          state_d    = SEND;
        end else begin
          frm_d   = 1'b1;
          timer_d = '0;
          state_d = WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        timer_d = timer_q + TW'(1);
        if (rx_new) begin
          resp_d     = rx_data;
          resp_rdy_d = 1'b1;
          pop        = 1'b1;
          state_d    = IDLE;
        end else if (timeout) begin
          if (retry_q < RW'(MAX_RETRY)) begin
            // Head entry is still in the FIFO, so reload the frame from it.
            retry_d    = retry_q + RW'(1);
            byte_idx_d = '0;
            shift_d    = head;
            state_d    = SEND;
          end else begin
            err_new = 1'b1;
            pop     = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    err_d  = (err_q && !clr_err) || err_new;
    ovfl_d = (ovfl_q && !clr_err) || (snd_cmd && q_full && !pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      byte_idx_q <= '0;
      retry_q    <= '0;
      timer_q    <= '0;
      tx_data_q  <= '0;
      resp_q     <= '0;
      trmt_q     <= 1'b0;
      frm_q      <= 1'b0;
      clr_rx_q   <= 1'b0;
      resp_rdy_q <= 1'b0;
      err_q      <= 1'b0;
      ovfl_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      byte_idx_q <= byte_idx_d;
      retry_q    <= retry_d;
      timer_q    <= timer_d;
      tx_data_q  <= tx_data_d;
      resp_q     <= resp_d;
      trmt_q     <= trmt_d;
      frm_q      <= frm_d;
      clr_rx_q   <= clr_rx_d;
      resp_rdy_q <= resp_rdy_d;
      err_q      <= err_d;
      ovfl_q     <= ovfl_d;
    end
  end

  assign tx_data    = tx_data_q;
  assign trmt       = trmt_q;
  assign frm_snt    = frm_q;
  assign clr_rx_rdy = clr_rx_q;
  assign resp       = resp_q;
  assign resp_rdy   = resp_rdy_q;
  assign err        = err_q;
  assign ovfl       = ovfl_q;
  assign busy       = (state_q != IDLE);
endmodule

// File: tb/tb_comm_master_q.sv
// Directed bench for comm_master_q: a 2-byte instance with a UART/copter model
// and a 4-byte instance driven inline.
module tb_comm_master_q;
  import comm_pkg::*;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic [7:0]  cmd = '0, tx_data, rx_data = '0, resp;
  logic [15:0] data = '0;
  logic        snd_cmd = 1'b0, q_full, ovfl, trmt, tx_done = 1'b0, rx_rdy = 1'b0;
  logic        clr_rx_rdy, resp_rdy, clr_resp_rdy = 1'b0, frm_snt, err, clr_err = 1'b0, busy;
  logic [2:0]  q_cnt;

  logic [7:0]  cmd4 = '0, tx_data4, rx_data4 = '0, resp4;
  logic [31:0] data4 = '0;
  logic        snd_cmd4 = 1'b0, q_full4, ovfl4, trmt4, tx_done4 = 1'b0, rx_rdy4 = 1'b0;
  logic        clr_rx_rdy4, resp_rdy4, frm_snt4, err4, busy4;
  logic [2:0]  q_cnt4;

  comm_master_q #(.DATA_BYTES(2), .QDEPTH(4), .TIMEOUT_CYC(1000), .MAX_RETRY(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .cmd(cmd), .data(data), .snd_cmd(snd_cmd), .q_full(q_full),
    .q_cnt(q_cnt), .ovfl(ovfl), .tx_data(tx_data), .trmt(trmt), .tx_done(tx_done),
    .rx_data(rx_data), .rx_rdy(rx_rdy), .clr_rx_rdy(clr_rx_rdy), .resp(resp),
    .resp_rdy(resp_rdy), .clr_resp_rdy(clr_resp_rdy), .frm_snt(frm_snt), .err(err),
    .clr_err(clr_err), .busy(busy));

  comm_master_q #(.DATA_BYTES(4), .QDEPTH(4), .TIMEOUT_CYC(100), .MAX_RETRY(2)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .cmd(cmd4), .data(data4), .snd_cmd(snd_cmd4), .q_full(q_full4),
    .q_cnt(q_cnt4), .ovfl(ovfl4), .tx_data(tx_data4), .trmt(trmt4), .tx_done(tx_done4),
    .rx_data(rx_data4), .rx_rdy(rx_rdy4), .clr_rx_rdy(clr_rx_rdy4), .resp(resp4),
    .resp_rdy(resp_rdy4), .clr_resp_rdy(1'b0), .frm_snt(frm_snt4), .err(err4),
    .clr_err(1'b0), .busy(busy4));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // UART + copter model for u_dut, evaluated on the falling edge.
  logic [7:0] txlog[$];
  int         trq[$], frmq[$];
  int         txcd = 0, rxcd = 0;
  logic       reply_en = 1'b1, inj_tog = 1'b0, inj_seen = 1'b0;
  logic [7:0] reply_val = 8'h00;
  int         reply_dly = 5;

  always @(negedge clk) begin
    tx_done = 1'b0;
    if (!rst_n) begin
      txcd = 0; rxcd = 0; rx_rdy = 1'b0;
    end else begin
      if (txcd != 0) begin txcd--; if (txcd == 0) tx_done = 1'b1; end
      if (trmt) begin txlog.push_back(tx_data); trq.push_back(cyc); txcd = 3; end
      if (clr_rx_rdy) rx_rdy = 1'b0;
      if (rxcd != 0) begin
        rxcd--;
        if (rxcd == 0) begin rx_rdy = 1'b1; rx_data = reply_val; end
      end
      if (frm_snt) begin frmq.push_back(cyc); if (reply_en) rxcd = reply_dly; end
      if (inj_tog != inj_seen) begin inj_seen = inj_tog; rx_rdy = 1'b1; rx_data = 8'h99; end
    end
  end

  int n_chk = 0, n_pass = 0, rd_idx = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [39:0] take(input int n);
    logic [39:0] v = '0;
    for (int i = 0; i < n; i++) begin
      v = {v[31:0], (rd_idx < txlog.size()) ? txlog[rd_idx] : 8'hEE};
      rd_idx++;
    end
    return v;
  endfunction

  task automatic enq(input logic [7:0] c, input logic [15:0] d);
    cmd = c; data = d; snd_cmd = 1'b1;
    @(negedge clk);
    snd_cmd = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int maxc);
    int i = 0;
    do begin @(negedge clk); i++; end while ((busy || q_cnt != 0) && i < maxc);
    chk(tag, {63'd0, busy || q_cnt != 0}, 64'd0);
  endtask

  task automatic pulse_clr_resp();
    clr_resp_rdy = 1'b1; @(negedge clk); clr_resp_rdy = 1'b0; @(negedge clk);
  endtask

  task automatic chk_reset(input string tag);
    chk(tag, {tx_data, trmt, resp, resp_rdy, frm_snt, err, ovfl, q_full, q_cnt, busy, clr_rx_rdy},
        64'd0);
  endtask

  initial begin
    int fb, tb, ecyc, nb, nf, cd, seen;
    logic [39:0] b4;

    repeat (2) @(negedge clk);
    chk_reset("reset_outputs");
    chk("reset_outputs4", {tx_data4, trmt4, resp4, resp_rdy4, frm_snt4, err4, busy4, q_cnt4}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // REQ_BATT, reply C0, first-trmt and byte-spacing latency
    reply_val = 8'hC0; fb = frmq.size(); tb = trq.size();
    enq(REQ_BATT, 16'h0000);
    chk("qcnt_visible", q_cnt, 1);
    @(negedge clk); chk("trmt_not_yet", trmt, 0);
    @(negedge clk); chk("trmt_first", {trmt, tx_data}, {1'b1, 8'h01});
    wait_idle("batt_idle", 200);
    chk("batt_bytes", take(3), 40'h0000010000);
    chk("batt_frm_cnt", frmq.size() - fb, 1);
    chk("batt_byte_gap", trq[tb+1] - trq[tb], 5);
    chk("batt_frm_lat", frmq[fb] - trq[tb+2], 4);
    chk("batt_resp", {resp_rdy, resp, q_cnt}, {1'b1, 8'hC0, 3'd0});
    pulse_clr_resp();
    chk("resp_rdy_clr", resp_rdy, 0);

    // SET_PTCH 003A, reply A5
    reply_val = POS_ACK;
    enq(SET_PTCH, 16'h003A);
    wait_idle("ptch_idle", 200);
    chk("ptch_bytes", take(3), 40'h000002003A);
    chk("ptch_resp", {resp_rdy, resp}, {1'b1, 8'hA5});

    // DATA_BYTES=4 instance, DEADBEEF
    cmd4 = SET_PTCH; data4 = 32'hDEADBEEF; snd_cmd4 = 1'b1;
    @(negedge clk); snd_cmd4 = 1'b0;
    b4 = '0; nb = 0; nf = 0; cd = 0;
    for (int i = 0; i < 300 && !resp_rdy4; i++) begin
      @(negedge clk);
      tx_done4 = 1'b0;
      if (cd != 0) begin cd--; if (cd == 0) tx_done4 = 1'b1; end
      if (trmt4) begin b4 = {b4[31:0], tx_data4}; nb++; cd = 2; end
      if (clr_rx_rdy4) rx_rdy4 = 1'b0;
      if (frm_snt4) begin nf++; rx_rdy4 = 1'b1; rx_data4 = POS_ACK; end
    end
    rx_rdy4 = 1'b0;
    chk("d4_done", resp_rdy4, 1);
    chk("d4_bytes", b4, 40'h02DEADBEEF);
    chk("d4_counts", {nb[7:0], nf[7:0]}, {8'd5, 8'd1});
    chk("d4_resp", resp4, 8'hA5);

    // Fill the queue, then overflow
    fb = frmq.size();
    enq(8'h01, 16'h1111); enq(8'h02, 16'h2222); enq(8'h03, 16'h3333); enq(8'h04, 16'h4444);
    chk("full_after_4", {q_full, q_cnt}, {1'b1, 3'd4});
    enq(8'h05, 16'h5555);
    chk("ovfl_set", {ovfl, q_cnt}, {1'b1, 3'd4});
    wait_idle("fill_idle", 800);
    chk("fill_nbytes", txlog.size() - rd_idx, 12);
    chk("fill_f1", take(3), 40'h0000011111);
    chk("fill_f2", take(3), 40'h0000022222);
    chk("fill_f3", take(3), 40'h0000033333);
    chk("fill_f4", take(3), 40'h0000044444);
    chk("fill_frm_cnt", frmq.size() - fb, 4);
    clr_err = 1'b1; @(negedge clk); clr_err = 1'b0; @(negedge clk);
    chk("ovfl_clr", ovfl, 0);

    // No reply: three frames, err, next command proceeds
    reply_en = 1'b0; fb = frmq.size(); tb = trq.size();
    enq(8'h03, 16'h1234); enq(8'h04, 16'h0056);
    ecyc = -1;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (err) begin ecyc = cyc; break; end
    end
    reply_en = 1'b1; reply_val = 8'h3C;
    chk("to_err_seen", {63'd0, ecyc >= 0}, 1);
    chk("to_frames", frmq.size() - fb, 3);
    chk("to_trmts", trq.size() - tb, 9);
    if (frmq.size() - fb >= 3 && trq.size() - tb >= 9) begin
      chk("to_retry1_gap", trq[tb+3] - frmq[fb], 1001);
      chk("to_retry2_gap", trq[tb+6] - frmq[fb+1], 1001);
      chk("to_err_time", ecyc - frmq[fb+2], 1000);
    end
    chk("to_resp_kept", resp, 8'hA5);
    chk("to_f1", take(3), 40'h0000031234);
    chk("to_f2", take(3), 40'h0000031234);
    chk("to_f3", take(3), 40'h0000031234);
    wait_idle("to_next_idle", 300);
    chk("to_next_bytes", take(3), 40'h0000040056);
    chk("to_next_resp", {resp, err}, {8'h3C, 1'b1});
    clr_err = 1'b1; @(negedge clk); clr_err = 1'b0; @(negedge clk);
    chk("err_clr", err, 0);

    // Reply lands on the timeout cycle
    reply_dly = 999; reply_val = 8'h77; fb = frmq.size(); tb = trq.size();
    enq(8'h05, 16'h0102);
    wait_idle("coin_idle", 3000);
    reply_dly = 5;
    chk("coin_resp", {resp, err}, {8'h77, 1'b0});
    chk("coin_no_retry", {frmq.size() - fb, trq.size() - tb}, {32'd1, 32'd3});
    void'(take(3));

    // Stray byte while IDLE
    pulse_clr_resp();
    inj_tog = ~inj_tog;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (clr_rx_rdy) seen++;
    end
    chk("stray_ack", seen, 1);
    chk("stray_resp", {resp_rdy, resp, busy}, {1'b0, 8'h77, 1'b0});

    // Reset during the second byte of a 3-command burst
    tb = trq.size();
    enq(CALIBRATE, 16'h0A0B); enq(EMER_LAND, 16'h0C0D); enq(MTRS_OFF, 16'h0E0F);
    for (int i = 0; i < 100 && trq.size() < tb + 2; i++) @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset("midrst_outputs");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    chk("midrst_no_trmt", trq.size() - tb, 2);
    chk("midrst_qcnt", {q_cnt, busy}, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
